// File: rtl/div_pkg.sv
// Shared divider definitions: FSM state encoding, iteration-count helper,
// and the ALU function encodings that select divide/remainder flavours.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    function automatic int unsigned div_iters(input int unsigned width, input int unsigned bpc);
        return width / bpc;
    endfunction

endpackage

package sys_defs;

    typedef logic [4:0] alu_func_t;

    localparam alu_func_t ALU_DIV  = 5'h0C;
    localparam alu_func_t ALU_DIVU = 5'h0D;
    localparam alu_func_t ALU_REM  = 5'h0E;
    localparam alu_func_t ALU_REMU = 5'h0F;

endpackage

// File: rtl/iter_divider_if.sv
// Request/response channel of the iterative divider; the requester is the
// master, the divider the slave.
interface iter_divider_if
    import sys_defs::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    alu_func_t        in_func;
    logic [TAG_W-1:0] in_tag;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    alu_func_t        out_func;

    modport master (
        output in_valid, in_func, in_tag, opa, opb, out_ready,
        input  in_ready, out_valid, out_tag, quotient, remainder, out_func
    );

    modport slave (
        input  in_valid, in_func, in_tag, opa, opb, out_ready,
        output in_ready, out_valid, out_tag, quotient, remainder, out_func
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it did not borrow.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] dvd_o
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             qbit;

    always_comb begin
        shifted = {rem_i, dvd_i[WIDTH-1]};
        diff    = shifted - {2'b00, dsr_i};
        qbit    = ~diff[WIDTH+1];
        rem_o   = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
        // dividend register doubles as the quotient shift register
        dvd_o   = {dvd_i[WIDTH-2:0], qbit};
    end
endmodule

// File: rtl/iter_divider.sv
// Iterative restoring divider, BITS_PER_CYCLE quotient bits per BUSY cycle,
// with signed/unsigned divide and remainder and a single-result output stage.
module iter_divider
    import div_pkg::*;
    import sys_defs::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned TAG_W          = 5
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    iter_divider_if.slave bus
);
    localparam int unsigned      ITERS   = div_iters(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned      CNT_W   = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(ITERS - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    alu_func_t        func_q, func_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;

    logic             func_ok, is_signed, sign_a, sign_b, div0, ovf, accept;
    logic [WIDTH-1:0] mag_a, mag_b, qmag, rmag;

    logic [WIDTH:0]   rem_c [0:BITS_PER_CYCLE];
    logic [WIDTH-1:0] dvd_c [0:BITS_PER_CYCLE];

    assign rem_c[0] = rem_q;
    assign dvd_c[0] = dvd_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_i (rem_c[g]),
            .dvd_i (dvd_c[g]),
            .dsr_i (dsr_q),
            .rem_o (rem_c[g+1]),
            .dvd_o (dvd_c[g+1])
        );
    end

    assign qmag = dvd_c[BITS_PER_CYCLE];
    assign rmag = rem_c[BITS_PER_CYCLE][WIDTH-1:0];

    always_comb begin
        func_ok   = bus.in_func inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        is_signed = (bus.in_func == ALU_DIV) || (bus.in_func == ALU_REM);
        sign_a    = is_signed && bus.opa[WIDTH-1];
        sign_b    = is_signed && bus.opb[WIDTH-1];
        mag_a     = sign_a ? -bus.opa : bus.opa;
        mag_b     = sign_b ? -bus.opb : bus.opb;
        div0      = (bus.opb == '0);
        ovf       = is_signed && (bus.opa == MIN_VAL) && (bus.opb == '1);
        accept    = bus.in_valid && (state_q == S_IDLE) && func_ok && !flush;
    end

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        tag_d   = tag_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dsr_d   = dsr_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    func_d = bus.in_func;
                    tag_d  = bus.in_tag;
                    negq_d = sign_a ^ sign_b;
                    negr_d = sign_a;
                    dvd_d  = mag_a;
                    dsr_d  = mag_b;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (div0) begin
                        quot_d  = '1;
                        remo_d  = bus.opa;
                        state_d = S_DONE;
                    end else if (ovf) begin
                        quot_d  = bus.opa;
                        remo_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                rem_d = rem_c[BITS_PER_CYCLE];
                dvd_d = dvd_c[BITS_PER_CYCLE];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    quot_d  = negq_q ? -qmag : qmag;
                    remo_d  = negr_q ? -rmag : rmag;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // flush overrides both accept and the output handshake
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            func_q  <= '0;
            tag_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dsr_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            tag_q   <= tag_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dsr_q   <= dsr_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_tag   = tag_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = remo_q;
    assign bus.out_func  = func_q;
endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: one instance at 1 bit/cycle, one at 4 bits/cycle.
module tb_iter_divider;
    import sys_defs::*;

    logic clk;
    logic rst1, rst4, flush1, flush4;
    int   checks;
    int   fails;

    iter_divider_if #(.WIDTH(32), .TAG_W(5)) if1 ();
    iter_divider_if #(.WIDTH(32), .TAG_W(5)) if4 ();

    iter_divider #(.WIDTH(32), .BITS_PER_CYCLE(1), .TAG_W(5)) u_dut1 (
        .clk(clk), .rst(rst1), .flush(flush1), .bus(if1)
    );
    iter_divider #(.WIDTH(32), .BITS_PER_CYCLE(4), .TAG_W(5)) u_dut4 (
        .clk(clk), .rst(rst4), .flush(flush4), .bus(if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request, wait for its accept edge, scramble the inputs, then
    // count edges after the accept edge until out_valid (bounded).
    task automatic issue(input bit use4, input alu_func_t f, input logic [4:0] t,
                         input logic [31:0] a, input logic [31:0] b, output int lat);
        if (!use4) begin
            if1.in_valid = 1'b1; if1.in_func = f; if1.in_tag = t; if1.opa = a; if1.opb = b;
        end else begin
            if4.in_valid = 1'b1; if4.in_func = f; if4.in_tag = t; if4.opa = a; if4.opb = b;
        end
        @(posedge clk); #1;
        if (!use4) begin
            if1.in_valid = 1'b0; if1.in_func = ALU_REMU; if1.in_tag = 5'($urandom);
            if1.opa = $urandom; if1.opb = $urandom;
        end else begin
            if4.in_valid = 1'b0; if4.in_func = ALU_REMU; if4.in_tag = 5'($urandom);
            if4.opa = $urandom; if4.opb = $urandom;
        end
        lat = 0;
        while (!(use4 ? if4.out_valid : if1.out_valid) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume(input bit use4);
        if (!use4) if1.out_ready = 1'b1; else if4.out_ready = 1'b1;
        @(posedge clk); #1;
        if (!use4) if1.out_ready = 1'b0; else if4.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst1 = 1'b1; rst4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0; rst4 = 1'b0;
        checks++; if (if1.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b expected 1", if1.in_ready); end
        checks++; if (if1.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b expected 0", if1.out_valid); end
        checks++; if (if1.quotient !== 32'h0 || if1.remainder !== 32'h0) begin
            fails++; $display("FAIL rst_results: got q=%h r=%h expected 0/0", if1.quotient, if1.remainder); end
        checks++; if (if1.out_tag !== 5'd0 || if1.out_func !== 5'd0) begin
            fail_line("rst_tag_func", {27'd0, if1.out_tag}, {27'd0, if1.out_func}); end
        checks++; if (if4.in_ready !== 1'b1 || if4.out_valid !== 1'b0) begin
            fails++; $display("FAIL rst4_handshake: got in_ready=%b out_valid=%b expected 1/0", if4.in_ready, if4.out_valid); end
    endtask

    function automatic void fail_line(input string nm, input logic [31:0] a, input logic [31:0] b);
        fails++;
        $display("FAIL %s: got tag=%0h func=%0h expected 0/0", nm, a, b);
    endfunction

    task automatic test_divu;
        int lat;
        issue(1'b0, ALU_DIVU, 5'd3, 32'd100, 32'd7, lat);
        checks++; if (lat != 32) begin fails++; $display("FAIL divu_latency: got %0d expected 32", lat); end
        checks++; if (if1.quotient !== 32'd14) begin fails++; $display("FAIL divu_q: got %h expected %h", if1.quotient, 32'd14); end
        checks++; if (if1.remainder !== 32'd2) begin fails++; $display("FAIL divu_r: got %h expected %h", if1.remainder, 32'd2); end
        checks++; if (if1.out_tag !== 5'd3 || if1.out_func !== ALU_DIVU) begin
            fails++; $display("FAIL divu_tag_func: got %0d/%h expected 3/%h", if1.out_tag, if1.out_func, ALU_DIVU); end
        consume(1'b0);
        checks++; if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1) begin
            fails++; $display("FAIL divu_release: got out_valid=%b in_ready=%b expected 0/1", if1.out_valid, if1.in_ready); end
    endtask

    task automatic test_signed;
        int lat;
        issue(1'b0, ALU_DIV, 5'd4, 32'hFFFF_FFF9, 32'd2, lat);
        checks++; if (if1.quotient !== 32'hFFFF_FFFD || if1.remainder !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL div_neg: got q=%h r=%h expected fffffffd/ffffffff", if1.quotient, if1.remainder); end
        consume(1'b0);
        issue(1'b0, ALU_REM, 5'd5, 32'd7, 32'hFFFF_FFFE, lat);
        checks++; if (if1.quotient !== 32'hFFFF_FFFD || if1.remainder !== 32'd1) begin
            fails++; $display("FAIL rem_negdiv: got q=%h r=%h expected fffffffd/00000001", if1.quotient, if1.remainder); end
        checks++; if (lat != 32) begin fails++; $display("FAIL rem_latency: got %0d expected 32", lat); end
        consume(1'b0);
    endtask

    task automatic test_edges;
        int lat;
        issue(1'b0, ALU_DIVU, 5'd6, 32'd5, 32'd0, lat);
        checks++; if (lat != 0 || if1.quotient !== 32'hFFFF_FFFF || if1.remainder !== 32'd5) begin
            fails++; $display("FAIL divu_by0: got lat=%0d q=%h r=%h expected 0/ffffffff/00000005", lat, if1.quotient, if1.remainder); end
        consume(1'b0);
        issue(1'b0, ALU_REM, 5'd7, 32'hFFFF_FFFB, 32'd0, lat);
        checks++; if (lat != 0 || if1.quotient !== 32'hFFFF_FFFF || if1.remainder !== 32'hFFFF_FFFB) begin
            fails++; $display("FAIL rem_by0: got lat=%0d q=%h r=%h expected 0/ffffffff/fffffffb", lat, if1.quotient, if1.remainder); end
        consume(1'b0);
        issue(1'b0, ALU_DIV, 5'd8, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks++; if (lat != 0 || if1.quotient !== 32'h8000_0000 || if1.remainder !== 32'd0) begin
            fails++; $display("FAIL div_ovf: got lat=%0d q=%h r=%h expected 0/80000000/00000000", lat, if1.quotient, if1.remainder); end
        consume(1'b0);
        issue(1'b0, ALU_DIVU, 5'd9, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks++; if (lat != 32 || if1.quotient !== 32'd0 || if1.remainder !== 32'h8000_0000) begin
            fails++; $display("FAIL divu_big: got lat=%0d q=%h r=%h expected 32/00000000/80000000", lat, if1.quotient, if1.remainder); end
        consume(1'b0);
    endtask

    task automatic test_invalid_func;
        int seen;
        seen = 0;
        if1.in_valid = 1'b1; if1.in_func = 5'd0; if1.opa = 32'd10; if1.opb = 32'd2;
        repeat (3) begin
            @(posedge clk); #1;
            if (if1.in_ready !== 1'b1) seen++;
        end
        if1.in_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (if1.out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin fails++; $display("FAIL invalid_func: got %0d bad cycles expected 0", seen); end
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(1'b0, ALU_DIVU, 5'd7, 32'd1000, 32'd10, lat);
        if1.in_valid = 1'b1; if1.in_func = ALU_DIVU; if1.in_tag = 5'd11; if1.opa = 32'd50; if1.opb = 32'd5;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (if1.out_valid !== 1'b1 || if1.in_ready !== 1'b0 || if1.quotient !== 32'd100 ||
                if1.remainder !== 32'd0 || if1.out_tag !== 5'd7) begin
                fails++;
                $display("FAIL stall_%0d: got v=%b rdy=%b q=%h r=%h tag=%0d expected 1/0/00000064/00000000/7",
                         i, if1.out_valid, if1.in_ready, if1.quotient, if1.remainder, if1.out_tag);
            end
        end
        consume(1'b0);
        checks++; if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_release: got out_valid=%b in_ready=%b expected 0/1", if1.out_valid, if1.in_ready); end
        issue(1'b0, ALU_DIVU, 5'd11, 32'd50, 32'd5, lat);
        checks++; if (lat != 32 || if1.quotient !== 32'd10 || if1.remainder !== 32'd0 || if1.out_tag !== 5'd11) begin
            fails++; $display("FAIL b2b_second: got lat=%0d q=%h r=%h tag=%0d expected 32/0000000a/00000000/11",
                              lat, if1.quotient, if1.remainder, if1.out_tag); end
        consume(1'b0);
    endtask

    task automatic test_flush;
        int lat;
        int seen;
        if1.in_valid = 1'b1; if1.in_func = ALU_DIVU; if1.in_tag = 5'd9; if1.opa = 32'd100; if1.opb = 32'd7;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush1 = 1'b1;
        @(posedge clk); #1;
        flush1 = 1'b0;
        checks++; if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_busy: got in_ready=%b out_valid=%b expected 1/0", if1.in_ready, if1.out_valid); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (if1.out_valid !== 1'b0) seen++; end
        checks++; if (seen != 0) begin fails++; $display("FAIL flush_no_result: got %0d valid cycles expected 0", seen); end
        issue(1'b0, ALU_DIVU, 5'd10, 32'd9, 32'd3, lat);
        checks++; if (lat != 32 || if1.quotient !== 32'd3 || if1.remainder !== 32'd0) begin
            fails++; $display("FAIL flush_next: got lat=%0d q=%h r=%h expected 32/00000003/00000000", lat, if1.quotient, if1.remainder); end
        consume(1'b0);
        // flush while a request is offered in IDLE: must not be accepted
        if1.in_valid = 1'b1; if1.in_func = ALU_DIVU; if1.opa = 32'd5; if1.opb = 32'd0;
        flush1 = 1'b1;
        @(posedge clk); #1;
        flush1 = 1'b0; if1.in_valid = 1'b0;
        checks++; if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_vs_accept: got in_ready=%b out_valid=%b expected 1/0", if1.in_ready, if1.out_valid); end
        // flush in DONE discards the held result
        issue(1'b0, ALU_DIVU, 5'd12, 32'd5, 32'd0, lat);
        flush1 = 1'b1;
        @(posedge clk); #1;
        flush1 = 1'b0;
        checks++; if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_done: got out_valid=%b in_ready=%b expected 0/1", if1.out_valid, if1.in_ready); end
    endtask

    task automatic test_bpc4;
        int lat;
        int seen;
        issue(1'b1, ALU_DIVU, 5'd13, 32'hFFFF_FFFF, 32'd3, lat);
        checks++; if (lat != 8) begin fails++; $display("FAIL bpc4_latency: got %0d expected 8", lat); end
        checks++; if (if4.quotient !== 32'h5555_5555 || if4.remainder !== 32'd0) begin
            fails++; $display("FAIL bpc4_divu: got q=%h r=%h expected 55555555/00000000", if4.quotient, if4.remainder); end
        consume(1'b1);
        issue(1'b1, ALU_DIV, 5'd14, 32'hFFFF_FF9C, 32'd7, lat);
        checks++; if (lat != 8 || if4.quotient !== 32'hFFFF_FFF2 || if4.remainder !== 32'hFFFF_FFFE) begin
            fails++; $display("FAIL bpc4_div: got lat=%0d q=%h r=%h expected 8/fffffff2/fffffffe", lat, if4.quotient, if4.remainder); end
        consume(1'b1);
        if4.in_valid = 1'b1; if4.in_func = ALU_DIVU; if4.in_tag = 5'd15; if4.opa = 32'd1000; if4.opb = 32'd3;
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst4 = 1'b1; flush4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0; flush4 = 1'b0;
        checks++; if (if4.in_ready !== 1'b1 || if4.out_valid !== 1'b0 || if4.quotient !== 32'd0) begin
            fails++; $display("FAIL bpc4_rst_busy: got in_ready=%b out_valid=%b q=%h expected 1/0/00000000",
                              if4.in_ready, if4.out_valid, if4.quotient); end
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (if4.out_valid !== 1'b0) seen++; end
        checks++; if (seen != 0) begin fails++; $display("FAIL bpc4_rst_no_result: got %0d valid cycles expected 0", seen); end
    endtask

    initial begin
        checks = 0; fails = 0;
        rst1 = 1'b1; rst4 = 1'b1; flush1 = 1'b0; flush4 = 1'b0;
        if1.in_valid = 1'b0; if1.in_func = ALU_DIVU; if1.in_tag = '0; if1.opa = '0; if1.opb = '0; if1.out_ready = 1'b0;
        if4.in_valid = 1'b0; if4.in_func = ALU_DIVU; if4.in_tag = '0; if4.opa = '0; if4.opb = '0; if4.out_ready = 1'b0;
        test_reset();
        test_divu();
        test_signed();
        test_edges();
        test_invalid_func();
        test_back_to_back();
        test_flush();
        test_bpc4();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; even, >=8.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: quotient bits resolved per BUSY cycle; one of 1, 2, 4; divides WIDTH.
REQ-003 SHALL have parameter TAG_W, default 5: width of the opaque tag carried from request to result.
REQ-004 SHALL have one clock and a synchronous active-high reset, ports clk and rst, and ports as follows (clock and reset first):
 clk  in  1  clock, all state updates on rising edge
 rst  in  1  synchronous active-high reset
 flush  in  1  abort any operation in flight
 in_valid  in  1  request present
 in_ready  out  1  request accepted when high with in_valid
 in_func  in  5  ALU func code: ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
 in_tag  in  TAG_W  opaque tag
 opa  in  WIDTH  dividend
 opb  in  WIDTH  divisor
 out_valid  out  1  result present
 out_ready  in  1  result consumed when high with out_valid
 out_tag  out  TAG_W  tag of the accepted request
 quotient  out  WIDTH  quotient
 remainder  out  WIDTH  remainder
 out_func  out  5  func of the accepted request

Function
REQ-005 SHALL implement states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-006 Accept (in_valid && in_ready at edge) SHALL latch func, tag, operand magnitudes and signs; func outside the four codes SHALL be ignored (no accept, in_ready stays 1).
REQ-007 Signed funcs (DIV, REM) SHALL divide magnitudes; quotient negated when opa/opb signs differ, remainder takes sign of opa.
REQ-008 Divide-by-zero (opb==0) SHALL go IDLE->DONE in one cycle with quotient all-ones, remainder=opa.
REQ-009 Signed overflow (opa==MIN, opb==all-ones, signed func) SHALL go IDLE->DONE in one cycle with quotient=opa, remainder=0.
REQ-010 Otherwise SHALL enter BUSY for exactly WIDTH/BITS_PER_CYCLE cycles of restoring division, MSB first, then DONE; out_valid SHALL assert after accept edge + WIDTH/BITS_PER_CYCLE edges.
REQ-011 Latency SHALL be data-independent for non-edge cases (no early termination).
REQ-012 In DONE, out_valid=1; quotient, remainder, out_tag, out_func SHALL be registered and stable until out_ready=1; DONE->IDLE on out_valid && out_ready.
REQ-013 flush SHALL force IDLE at the next edge from any state, discard the result, and take priority over accept and over out handshake in the same cycle.
REQ-014 Back-to-back: a new request SHALL be accepted no earlier than the cycle after the DONE->IDLE handshake.
REQ-015 Inputs opa/opb/in_func SHALL NOT be required stable after accept.
REQ-016 All arithmetic SHALL be WIDTH-bit modular; partial remainder held in WIDTH+1 bits.

Reset
REQ-017 rst SHALL set state IDLE, out_valid=0, quotient=0, remainder=0, out_tag=0, out_func=0, internal counters/partial remainder to 0; in_ready=1 from the first cycle after reset.
REQ-018 rst mid-BUSY or in DONE SHALL discard the operation with no result emitted; rst dominates flush.

Structure
REQ-019 State enum typedef and iteration-count constant function SHALL live in shared package div_pkg; ALU func codes SHALL come from the shared sys_defs definitions.
REQ-020 One restoring step SHALL be sub-module div_step (combinational, WIDTH-parametrised), instantiated BITS_PER_CYCLE times in a chain.

Verification
REQ-021 DIVU 100/7, BPC=1 -> quotient=14, remainder=2, out_valid exactly 32 cycles after accept edge.
REQ-022 DIV 0xFFFFFFF9/2 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; REM 7/0xFFFFFFFE -> remainder=1, quotient=0xFFFFFFFD.
REQ-023 DIVU 5/0 -> quotient=0xFFFFFFFF, remainder=5, one cycle; DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, one cycle.
REQ-024 out_ready=0 for 10 cycles in DONE -> outputs and out_tag unchanged, in_ready=0 throughout; handshake -> in_ready=1 next cycle.
REQ-025 flush on BUSY cycle 10 -> out_valid never asserts for that tag, in_ready=1 next cycle; following DIVU 9/3 -> quotient=3, remainder=0.
REQ-026 BPC=4: DIVU 0xFFFFFFFF/3 -> quotient=0x55555555, remainder=0, out_valid 8 cycles after accept; rst during BUSY -> no out_valid.
